// File: rtl/demux4_reg.sv
// Registered 1-to-4 demux with a one-entry buffer per channel; DEMUX4_REG_COUNT_EN adds per-channel delivery counters on cnt.
// Latency: one cycle from the accepting edge to y[s]/v[s]; no combinational bypass.
// Backpressure: in_ready = !v[s] | r[s], so only the selected channel can stall the producer.
module demux4_reg #(
    parameter int n = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [n-1:0] d,
    input  logic [1:0]   s,
    output logic [n-1:0] y0,
    output logic [n-1:0] y1,
    output logic [n-1:0] y2,
    output logic [n-1:0] y3,
    output logic         v0,
    output logic         v1,
    output logic         v2,
    output logic         v3,
    input  logic         r0,
    input  logic         r1,
    input  logic         r2,
    input  logic         r3
`ifdef DEMUX4_REG_COUNT_EN
    ,
    output logic [31:0]  cnt
`endif
);

    logic [n-1:0] y_q [4];
    logic [n-1:0] y_d [4];
    logic [3:0]   v_q;
    logic [3:0]   v_d;
    logic [3:0]   r_vec;
    logic [3:0]   drain;
    logic         load;

    assign r_vec    = {r3, r2, r1, r0};
    assign drain    = v_q & r_vec;
    assign in_ready = !v_q[s] || r_vec[s];
    assign load     = in_valid && in_ready;

    // A drain and a load on the same channel in one cycle keeps it full with the new word.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            y_d[k] = y_q[k];
            v_d[k] = v_q[k] && !r_vec[k];
            if (load && (s == 2'(k))) begin
                y_d[k] = d;
                v_d[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 4; k++) begin
                y_q[k] <= '0;
            end
            v_q <= '0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                y_q[k] <= y_d[k];
            end
            v_q <= v_d;
        end
    end

    assign y0 = y_q[0];
    assign y1 = y_q[1];
    assign y2 = y_q[2];
    assign y3 = y_q[3];
    assign v0 = v_q[0];
    assign v1 = v_q[1];
    assign v2 = v_q[2];
    assign v3 = v_q[3];

`ifdef DEMUX4_REG_COUNT_EN
    logic [7:0] cnt_q [4];
    logic [7:0] cnt_d [4];

    // 8-bit fields wrap naturally at 255 -> 0.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            cnt_d[k] = cnt_q[k] + {7'd0, drain[k]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 4; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    assign cnt = {cnt_q[3], cnt_q[2], cnt_q[1], cnt_q[0]};
`else
    logic unused_drain;
    assign unused_drain = ^drain;
`endif

endmodule
